scan_sequencer: RTL

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_pkg.sv | 20 ++
 rtl/scan_coord_step.sv | 95 +++++++++
 rtl/scan_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared scan definitions: mode encoding and default geometry for the scan
// sequencer, its coordinate stepper and the downstream edge detector.
package scan_pkg;

   typedef enum logic [1:0] {
      MODE_LR = 2'b00,
      MODE_UD = 2'b01,
      MODE_DL = 2'b10,
      MODE_DR = 2'b11
   } scan_mode_e;

   localparam int N_DEFAULT      = 150;
   localparam int ADDR_W_DEFAULT = 15;

   // Width of a row or column index for an N x N image (at least one bit).
   function automatic int coord_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/scan_coord_step.sv
// Combinational coordinate stepper: next (row, col, line_end) and last-beat flag
// for the current scan mode. Diagonal modes are built only with SCAN_SEQ_DIAG_EN.
module scan_coord_step
   import scan_pkg::*;
#(
   parameter int N  = N_DEFAULT,
   parameter int CW = coord_width(N)
) (
   input  logic [CW-1:0] row_i,
   input  logic [CW-1:0] col_i,
   input  logic [1:0]    mode_i,
   output logic [CW-1:0] nxt_row_o,
   output logic [CW-1:0] nxt_col_o,
   output logic          nxt_line_end_o,
   output logic          pass_last_o
);

   localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef SCAN_SEQ_DIAG_EN
   localparam logic [CW:0] LAST_X = (CW + 1)'(N - 1);
   logic [CW:0] diag_nxt;
`endif

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      nxt_row_o      = row_i;
      nxt_col_o      = col_i;
      nxt_line_end_o = 1'b0;
      pass_last_o    = 1'b0;
`ifdef SCAN_SEQ_DIAG_EN
      diag_nxt       = {1'b0, row_i} + {1'b0, col_i} + (CW + 1)'(1);
`endif
      case (mode_i)
         MODE_LR: begin
            pass_last_o = (row_i == LAST) && (col_i == LAST);
            if (col_i == LAST) begin
               nxt_row_o = row_i + 1'b1;
               nxt_col_o = '0;
            end else begin
               nxt_col_o = col_i + 1'b1;
            end
            nxt_line_end_o = (nxt_col_o == LAST);
         end
         MODE_UD: begin
            pass_last_o = (row_i == LAST) && (col_i == LAST);
            if (row_i == LAST) begin
               nxt_row_o = '0;
               nxt_col_o = col_i + 1'b1;
            end else begin
               nxt_row_o = row_i + 1'b1;
            end
            nxt_line_end_o = (nxt_row_o == LAST);
         end
`ifdef SCAN_SEQ_DIAG_EN
         MODE_DL: begin
            pass_last_o = (row_i == LAST) && (col_i == LAST);
            if ((col_i == '0) || (row_i == LAST)) begin
               // Next anti-diagonal d+1 starts on the top row or, past the corner, on the right edge.
               if (diag_nxt > LAST_X) begin
                  nxt_row_o = CW'(diag_nxt - LAST_X);
                  nxt_col_o = LAST;
               end else begin
                  nxt_row_o = '0;
                  nxt_col_o = CW'(diag_nxt);
               end
            end else begin
               nxt_row_o = row_i + 1'b1;
               nxt_col_o = col_i - 1'b1;
            end
            nxt_line_end_o = (nxt_col_o == '0) || (nxt_row_o == LAST);
         end
         MODE_DR: begin
            pass_last_o = (row_i == LAST) && (col_i == '0);
            if ((col_i == LAST) || (row_i == LAST)) begin
               // Above the main diagonal the next line starts on row 0, otherwise on column 0.
               if (row_i < col_i) begin
                  nxt_row_o = '0;
                  nxt_col_o = col_i - row_i - 1'b1;
               end else begin
                  nxt_row_o = row_i - col_i + 1'b1;
                  nxt_col_o = '0;
               end
            end else begin
               nxt_row_o = row_i + 1'b1;
               nxt_col_o = col_i + 1'b1;
            end
            nxt_line_end_o = (nxt_col_o == LAST) || (nxt_row_o == LAST);
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/scan_sequencer.sv
// Frame scan sequencer: issues pixel addresses in LR, UD (and, with
// SCAN_SEQ_DIAG_EN, DL and DR) passes over an N x N image with ready/valid handshake.
module scan_sequencer
   import scan_pkg::*;
#(
   parameter int N      = N_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              resetIn,
   input  logic              start,
   input  logic              addr_ready,
   output logic              addr_valid,
   output logic [ADDR_W-1:0] addr,
   output logic [1:0]        mode,
   output logic              line_end,
   output logic              pass_done,
   output logic              busy
);

   localparam int            CW     = coord_width(N);
   localparam logic [CW-1:0] LAST   = CW'(N - 1);
   localparam logic          SINGLE = (N == 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LR,
      ST_UD,
      ST_DL,
      ST_DR,
      ST_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     row_q, row_d;
   logic [CW-1:0]     col_q, col_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              line_end_q, line_end_d;
   logic              pass_done_q, pass_done_d;

   logic [CW-1:0]     step_row, step_col;
   logic              step_line_end, step_last;
   logic              transfer;

   scan_coord_step #(
      .N  (N),
      .CW (CW)
   ) u_step (
      .row_i          (row_q),
      .col_i          (col_q),
      .mode_i         (mode),
      .nxt_row_o      (step_row),
      .nxt_col_o      (step_col),
      .nxt_line_end_o (step_line_end),
      .pass_last_o    (step_last)
   );

   always_comb begin
      addr_valid = 1'b0;
      mode       = MODE_LR;
      case (state_q)
         ST_LR: addr_valid = 1'b1;
         ST_UD: begin
            addr_valid = 1'b1;
            mode       = MODE_UD;
         end
`ifdef SCAN_SEQ_DIAG_EN
         ST_DL: begin
            addr_valid = 1'b1;
            mode       = MODE_DL;
         end
         ST_DR: begin
            addr_valid = 1'b1;
            mode       = MODE_DR;
         end
`endif
         default: ;
      endcase
   end

   assign busy      = (state_q != ST_IDLE);
   assign transfer  = addr_valid && addr_ready;
   assign addr      = addr_q;
   assign line_end  = line_end_q;
   assign pass_done = pass_done_q;

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      line_end_d  = line_end_q;
      pass_done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_LR;
               row_d      = '0;
               col_d      = '0;
               line_end_d = SINGLE;
            end
         end
         ST_LR, ST_UD, ST_DL, ST_DR: begin
            if (transfer) begin
               if (step_last) begin
                  // Load the first coordinate of the following pass on the last beat.
                  pass_done_d = 1'b1;
                  row_d       = '0;
                  col_d       = '0;
                  line_end_d  = SINGLE;
                  case (state_q)
                     ST_LR: state_d = ST_UD;
`ifdef SCAN_SEQ_DIAG_EN
                     ST_UD: begin
                        state_d    = ST_DL;
                        line_end_d = 1'b1;
                     end
                     ST_DL: begin
                        state_d    = ST_DR;
                        col_d      = LAST;
                        line_end_d = 1'b1;
                     end
`endif
                     default: state_d = ST_DONE;
                  endcase
               end else begin
                  row_d      = step_row;
                  col_d      = step_col;
                  line_end_d = step_line_end;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      addr_d = ADDR_W'(row_d) * ADDR_W'(N) + ADDR_W'(col_d);
   end

   // NOTE: sequential state uses non-blocking assignments and an asynchronous reset
   // so outputs clear the moment resetIn rises, independent of clk.
   always_ff @(posedge clk or posedge resetIn) begin
      if (resetIn) begin
         state_q     <= ST_IDLE;
         row_q       <= '0;
         col_q       <= '0;
         addr_q      <= '0;
         line_end_q  <= 1'b0;
         pass_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         addr_q      <= addr_d;
         line_end_q  <= line_end_d;
         pass_done_q <= pass_done_d;
      end
   end

endmodule
